packet_rr_arbiter: RTL and testbench

- Per-output-port switch allocator for the NoC Router; one instance per output port.
- Shares the output port among INPUTS input FIFOs at packet granularity, using wormhole switching.
- A grant is locked from head flit to tail flit, or until FlitPerPacket flits have moved, whichever comes first.
- Fairness between inputs is round-robin.
- The router crossbar select uses grant_idx. The router qualifies output valid/ready with grant.

---
 rtl/packet_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_packet_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// rtl/packet_rr_arbiter.sv - per-output-port wormhole switch allocator with round-robin packet arbitration
module packet_rr_arbiter #(
    parameter int INPUTS        = 3,
    parameter int REQUEST_WIDTH = $clog2(INPUTS),
    parameter int FlitPerPacket = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INPUTS-1:0]        req_bus,
    input  logic                     xfer,
    input  logic                     tail_in,
    output logic [INPUTS-1:0]        grant,
    output logic [REQUEST_WIDTH-1:0] grant_idx,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     pkt_err
);

    localparam int FLIT_CNT_W = $clog2(FlitPerPacket + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]               state_q,     state_d;
    logic [REQUEST_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;
    logic [FLIT_CNT_W-1:0]    flit_cnt_q,  flit_cnt_d;
    logic [INPUTS-1:0]        grant_q,     grant_d;
    logic [REQUEST_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic                     pkt_done_q,  pkt_done_d;
    logic                     pkt_err_q,   pkt_err_d;

    logic                     sel_found;
    logic [REQUEST_WIDTH-1:0] sel_idx;
    logic                     last_flit;

    // Search upward from rr_ptr so the input served last is considered last.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < INPUTS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= INPUTS) begin
                cand = cand - INPUTS;
            end
            if (!sel_found && req_bus[cand]) begin
                sel_found = 1'b1;
                sel_idx   = REQUEST_WIDTH'(cand);
            end
        end
    end

    assign last_flit = tail_in || (flit_cnt_q == FLIT_CNT_W'(FlitPerPacket - 1));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        flit_cnt_d  = flit_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = LOCKED;
                    grant_d     = INPUTS'(1) << sel_idx;
                    grant_idx_d = sel_idx;
                    flit_cnt_d  = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    flit_cnt_d = flit_cnt_q + FLIT_CNT_W'(1);
                    if (last_flit) begin
                        // A tail on the length-limit flit is a clean end, not an error.
                        state_d     = IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                        flit_cnt_d  = '0;
                        pkt_done_d  = 1'b1;
                        pkt_err_d   = !tail_in;
                        rr_ptr_d    = (grant_idx_q == REQUEST_WIDTH'(INPUTS - 1))
                                      ? '0 : grant_idx_q + REQUEST_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            flit_cnt_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            flit_cnt_q  <= flit_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == LOCKED);
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// tb/tb_packet_rr_arbiter.sv - directed self-checking bench for packet_rr_arbiter
module tb_packet_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req_bus;
    logic       xfer;
    logic       tail_in;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       pkt_done;
    logic       pkt_err;

    int errors = 0;
    int checks = 0;

    packet_rr_arbiter #(
        .INPUTS(3),
        .REQUEST_WIDTH(2),
        .FlitPerPacket(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_bus(req_bus),
        .xfer(xfer),
        .tail_in(tail_in),
        .grant(grant),
        .grant_idx(grant_idx),
        .busy(busy),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n flits; tail on the last one when with_tail is set. xfer is dropped after the last edge.
    task automatic send_pkt(input int n, input bit with_tail);
        for (int i = 0; i < n; i++) begin
            xfer    = 1'b1;
            tail_in = with_tail && (i == n - 1);
            tick();
        end
        xfer    = 1'b0;
        tail_in = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] g, input logic [1:0] idx);
        check({tag, "_grant"}, grant, g);
        check({tag, "_idx"}, grant_idx, idx);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic expect_release(input string tag, input logic err);
        check({tag, "_rel_grant"}, grant, 3'b000);
        check({tag, "_rel_busy"}, busy, 1'b0);
        check({tag, "_rel_done"}, pkt_done, 1'b1);
        check({tag, "_rel_err"}, pkt_err, err);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("inv_xfer_needs_grant", xfer && !busy, 1'b0);
            check("inv_busy_eq_grant", busy, grant != 3'b000);
            check("inv_onehot0", $onehot0(grant), 1'b1);
            if (busy) begin
                check("inv_idx_match", grant, 3'b001 << grant_idx);
                check("inv_no_done_busy", pkt_done || pkt_err, 1'b0);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        req_bus = 3'b000;
        xfer    = 1'b0;
        tail_in = 1'b0;
        tick();
        tick();
        check("rst_grant", grant, 3'b000);
        check("rst_idx", grant_idx, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", pkt_done, 1'b0);
        check("rst_err", pkt_err, 1'b0);
        rst = 1'b0;

        // Idle with no requests stays idle
        tick();
        check("idle_grant", grant, 3'b000);

        // Basic grant to input 1, six flits with tail on sixth
        req_bus = 3'b010;
        tick();
        expect_grant("t1", 3'b010, 2'd1);
        req_bus = 3'b000;
        send_pkt(5, 1'b0);
        check("t1_still_busy", busy, 1'b1);
        send_pkt(1, 1'b1);
        expect_release("t1", 1'b0);
        req_bus = 3'b111;
        tick();
        check("t1_done_pulse", pkt_done, 1'b0);
        expect_grant("t1_next", 3'b100, 2'd2);

        // Rotation with all requesting, one idle bubble between packets
        send_pkt(6, 1'b1);
        expect_release("rot0", 1'b0);
        tick();
        expect_grant("rot1", 3'b001, 2'd0);
        send_pkt(6, 1'b1);
        expect_release("rot1", 1'b0);
        tick();
        expect_grant("rot2", 3'b010, 2'd1);
        send_pkt(6, 1'b1);
        expect_release("rot2", 1'b0);
        tick();
        expect_grant("rot3", 3'b100, 2'd2);
        send_pkt(6, 1'b1);
        expect_release("rot3", 1'b0);
        tick();
        expect_grant("rot4", 3'b001, 2'd0);

        // Lock holds through request changes; rr_ptr is now 1 after this packet
        req_bus = 3'b110;
        send_pkt(3, 1'b0);
        expect_grant("lock_mid", 3'b001, 2'd0);
        send_pkt(3, 1'b1);
        expect_release("lock", 1'b0);
        tick();
        expect_grant("lock_next", 3'b010, 2'd1);
        req_bus = 3'b100;
        send_pkt(2, 1'b1);
        expect_release("short2", 1'b0);
        tick();
        expect_grant("err_grant", 3'b100, 2'd2);

        // Length-limit release without tail, pointer wraps to 0
        req_bus = 3'b101;
        send_pkt(5, 1'b0);
        check("err_busy5", busy, 1'b1);
        send_pkt(1, 1'b0);
        expect_release("err", 1'b1);
        tick();
        check("err_one_cycle", pkt_err, 1'b0);
        expect_grant("wrap", 3'b001, 2'd0);

        // Single-flit packet on input 1, then a full packet proves the count restarted
        req_bus = 3'b010;
        send_pkt(1, 1'b1);
        expect_release("wrapfin", 1'b0);
        tick();
        expect_grant("single", 3'b010, 2'd1);
        req_bus = 3'b100;
        send_pkt(1, 1'b1);
        expect_release("single", 1'b0);
        tick();
        expect_grant("after_single", 3'b100, 2'd2);
        req_bus = 3'b000;
        send_pkt(5, 1'b0);
        check("cnt_restart_busy", busy, 1'b1);
        send_pkt(1, 1'b0);
        expect_release("cnt_restart", 1'b1);

        // Reset mid-packet: no pkt_done, pointer back to 0
        req_bus = 3'b010;
        tick();
        expect_grant("mid_rst", 3'b010, 2'd1);
        req_bus = 3'b000;
        send_pkt(3, 1'b0);
        rst = 1'b1;
        tick();
        check("mrst_grant", grant, 3'b000);
        check("mrst_idx", grant_idx, 2'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", pkt_done, 1'b0);
        check("mrst_err", pkt_err, 1'b0);
        rst     = 1'b0;
        req_bus = 3'b111;
        tick();
        expect_grant("post_rst", 3'b001, 2'd0);
        send_pkt(6, 1'b1);
        req_bus = 3'b000;
        tick();
        check("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
